// File: rtl/coef_mac_if.sv
// Term/result bundle between the mult pipeline, coef_mac and the downstream consumer.
// The master drives terms and prod; coef_mac is the slave and returns sums and status.
interface coef_mac_if;
    logic        clear;
    logic        op_valid;
    logic        op_last;
    logic [11:0] prod;
    logic        out_valid;
    logic [11:0] out_sum;
    logic        err_range;
    logic        err_len;
    logic        busy;

    modport master (
        output clear, op_valid, op_last, prod,
        input  out_valid, out_sum, err_range, err_len, busy
    );

    modport slave (
        input  clear, op_valid, op_last, prod,
        output out_valid, out_sum, err_range, err_len, busy
    );
endinterface

// File: rtl/coef_mac.sv
// Modular multiply-accumulate behind the mult pipeline: aligns {valid, last} tags with
// the multiplier latency and emits one sum mod Q per tagged group.
module coef_mac #(
    parameter int Q         = 3329,
    parameter int MULT_LAT  = 4,
    parameter int MAX_TERMS = 4
) (
    input  logic         clk,
    input  logic         rst,
    coef_mac_if.slave    bus
);
    localparam int              CW       = $clog2(MAX_TERMS + 1);
    localparam logic [12:0]     Q_W      = 13'(Q);
    localparam logic [CW-1:0]   CNT_SAT  = CW'(MAX_TERMS);
    localparam logic [CW-1:0]   CNT_WARN = CW'(MAX_TERMS - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    logic [MULT_LAT-1:0] r_dly_valid;
    logic [MULT_LAT-1:0] r_dly_last;
    logic [11:0]         r_acc;
    logic [CW-1:0]       r_cnt;
    logic                r_out_valid;
    logic [11:0]         r_out_sum;
    logic                r_err_range;
    logic                r_err_len;

    logic                w_tail_valid;
    logic                w_tail_last;
    logic [11:0]         w_base;
    logic [12:0]         w_sum_raw;
    logic [11:0]         w_sum;
    logic                w_prod_oor;

    // The tail of the delay line lines up with the product now on prod.
    assign w_tail_valid = r_dly_valid[MULT_LAT-1];
    assign w_tail_last  = r_dly_last[MULT_LAT-1];
    assign w_base       = (r_cnt == '0) ? 12'd0 : r_acc;
    assign w_sum_raw    = {1'b0, w_base} + {1'b0, bus.prod};
    assign w_sum        = (w_sum_raw >= Q_W) ? 12'(w_sum_raw - Q_W) : w_sum_raw[11:0];
    assign w_prod_oor   = ({1'b0, bus.prod} >= Q_W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dly_valid <= '0;
            r_dly_last  <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_err_range <= 1'b0;
            r_err_len   <= 1'b0;
        end else if (bus.clear) begin
            // Flush everything in flight, including a term offered this cycle.
            r_dly_valid <= '0;
            r_dly_last  <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_dly_valid <= {r_dly_valid[MULT_LAT-2:0], bus.op_valid};
            r_dly_last  <= {r_dly_last[MULT_LAT-2:0], bus.op_valid & bus.op_last};
            r_out_valid <= 1'b0;
            if (w_tail_valid) begin
                if (w_prod_oor) begin
                    r_err_range <= 1'b1;
                end
                if (w_tail_last) begin
                    r_out_sum   <= w_sum;
                    r_out_valid <= 1'b1;
                    r_acc       <= '0;
                    r_cnt       <= '0;
                end else begin
                    if (r_cnt == CNT_WARN) begin
                        r_err_len <= 1'b1;
                    end
                    r_acc <= w_sum;
                    if (r_cnt != CNT_SAT) begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_sum   = r_out_sum;
    assign bus.err_range = r_err_range;
    assign bus.err_len   = r_err_len;
    assign bus.busy      = (|r_dly_valid) | (r_cnt != '0);
endmodule

// File: tb/tb_coef_mac.sv
// Self-checking bench for coef_mac: directed group table, hand-written corner sequences,
// then random traffic checked every cycle against a group-level sum-mod-Q model.
`timescale 1ns/1ps
module tb_coef_mac;
    localparam int Q         = 3329;
    localparam int MULT_LAT  = 4;
    localparam int MAX_TERMS = 4;

    typedef struct packed {
        logic        v;
        logic        l;
        logic [11:0] p;
    } term_t;

    typedef struct packed {
        int               n;
        logic [4:0][11:0] p;
        int               gap_at;
        int               gap_len;
        logic [11:0]      exp_sum;
        logic             exp_err_len;
    } grp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    coef_mac_if bus();

    coef_mac #(.Q(Q), .MULT_LAT(MULT_LAT), .MAX_TERMS(MAX_TERMS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int    errors = 0;
    int    checks = 0;
    term_t pipe[$];
    int    m_sum, m_n, m_out;
    bit    m_ov, m_er, m_el;
    grp_t  tbl[4];
    grp_t  g_tmp;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic grp_t mk(input int n, input int a, input int b, input int c,
                                input int d, input int e, input int gap_at, input int gap_len,
                                input int sum, input bit el);
        grp_t g;
        g.n = n;
        g.p[0] = 12'(a); g.p[1] = 12'(b); g.p[2] = 12'(c); g.p[3] = 12'(d); g.p[4] = 12'(e);
        g.gap_at = gap_at;
        g.gap_len = gap_len;
        g.exp_sum = 12'(sum);
        g.exp_err_len = el;
        return g;
    endfunction

    task automatic model_reset();
        pipe.delete();
        repeat (MULT_LAT) pipe.push_back('0);
        m_sum = 0; m_n = 0; m_out = 0; m_ov = 0; m_er = 0; m_el = 0;
    endtask

    // One clock: offer a term, feed the product of the term issued MULT_LAT edges ago,
    // then compare every output against the model.
    task automatic cycle(input bit v, input bit l, input int p, input bit clr);
        term_t al, nw;
        int    s;
        bit    exp_busy;
        al   = pipe.pop_front();
        nw.v = v;
        nw.l = v & l;
        nw.p = 12'(p);
        bus.op_valid = v;
        bus.op_last  = l;
        bus.clear    = clr;
        bus.prod     = al.v ? al.p : 12'($urandom);
        @(posedge clk);
        #1;
        m_ov = 0;
        if (clr) begin
            pipe.delete();
            repeat (MULT_LAT) pipe.push_back('0);
            m_sum = 0;
            m_n   = 0;
        end else begin
            pipe.push_back(nw);
            if (al.v) begin
                if (al.p >= Q) m_er = 1;
                s = m_sum + al.p;
                if (s >= Q) s = s - Q;
                s = s % 4096;
                if (al.l) begin
                    m_ov  = 1;
                    m_out = s;
                    m_sum = 0;
                    m_n   = 0;
                end else begin
                    if (m_n == MAX_TERMS - 1) m_el = 1;
                    m_sum = s;
                    m_n++;
                end
            end
        end
        exp_busy = (m_n != 0);
        foreach (pipe[i]) if (pipe[i].v) exp_busy = 1;
        chk("out_valid", bus.out_valid, m_ov);
        chk("out_sum", bus.out_sum, m_out);
        chk("err_range", bus.err_range, m_er);
        chk("err_len", bus.err_len, m_el);
        chk("busy", bus.busy, exp_busy);
        if (bus.out_valid) $display("t=%0t sum=%0d", $time, bus.out_sum);
    endtask

    task automatic run_grp(input grp_t g, input string name);
        int seen;
        for (int i = 0; i < g.n; i++) begin
            cycle(1'b1, i == g.n - 1, int'(g.p[i]), 1'b0);
            if (i == g.gap_at) begin
                for (int k = 0; k < g.gap_len; k++) begin
                    cycle(1'b0, 1'b0, 0, 1'b0);
                    chk({name, " gap pulse"}, bus.out_valid, 0);
                end
            end
        end
        seen = 0;
        for (int k = 1; k <= MULT_LAT + 2 && seen == 0; k++) begin
            cycle(1'b0, 1'b0, 0, 1'b0);
            if (bus.out_valid) seen = k;
        end
        chk({name, " latency"}, seen, MULT_LAT);
        chk({name, " sum"}, bus.out_sum, g.exp_sum);
        chk({name, " err_len"}, bus.err_len, g.exp_err_len);
        cycle(1'b0, 1'b0, 0, 1'b0);
        chk({name, " busy after"}, bus.busy, 0);
    endtask

    initial begin
        int pulses;
        bus.clear = 0; bus.op_valid = 0; bus.op_last = 0; bus.prod = 0;
        tbl[0] = mk(3, 3000, 3000, 3000, 0, 0, -1, 0, 2342, 1'b0);
        tbl[1] = mk(3, 100, 200, 3100, 0, 0, 0, 3, 71, 1'b0);
        tbl[2] = mk(5, 1, 1, 1, 1, 1, -1, 0, 5, 1'b1);
        tbl[3] = mk(2, 5, 7, 0, 0, 0, -1, 0, 12, 1'b1);

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset out_valid", bus.out_valid, 0);
        chk("reset out_sum", bus.out_sum, 0);
        chk("reset err_range", bus.err_range, 0);
        chk("reset err_len", bus.err_len, 0);
        chk("reset busy", bus.busy, 0);
        rst = 1'b0;

        for (int r = 0; r < 3; r++) run_grp(tbl[r], $sformatf("grp%0d", r));

        // Single-term groups on consecutive cycles.
        cycle(1'b1, 1'b1, 1234, 1'b0);
        cycle(1'b1, 1'b1, 3328, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            cycle(1'b0, 1'b0, 0, 1'b0);
            if (k == 3) begin
                chk("b2b first pulse", bus.out_valid, 1);
                chk("b2b first sum", bus.out_sum, 1234);
            end
            if (k == 4) begin
                chk("b2b second pulse", bus.out_valid, 1);
                chk("b2b second sum", bus.out_sum, 3328);
            end
        end

        // Out-of-range product.
        cycle(1'b1, 1'b1, 3329, 1'b0);
        repeat (5) cycle(1'b0, 1'b0, 0, 1'b0);
        chk("range set", bus.err_range, 1);

        // Clear on the same edge the last term aligns: no pulse.
        cycle(1'b1, 1'b1, 50, 1'b0);
        repeat (MULT_LAT - 1) cycle(1'b0, 1'b0, 0, 1'b0);
        cycle(1'b0, 1'b0, 0, 1'b1);
        chk("clear vs last pulse", bus.out_valid, 0);
        chk("range after clear", bus.err_range, 1);

        // Clear two cycles after the first operand of a 3-term group.
        pulses = 0;
        cycle(1'b1, 1'b0, 10, 1'b0);
        cycle(1'b1, 1'b0, 20, 1'b0);
        cycle(1'b1, 1'b1, 30, 1'b1);
        for (int k = 0; k < 6; k++) begin
            cycle(1'b0, 1'b0, 0, 1'b0);
            if (bus.out_valid) pulses++;
        end
        chk("clear flush pulses", pulses, 0);
        chk("clear flush busy", bus.busy, 0);
        chk("err_len kept by clear", bus.err_len, 1);
        run_grp(tbl[3], "after clear");

        // Asynchronous reset mid-group.
        cycle(1'b1, 1'b0, 300, 1'b0);
        cycle(1'b1, 1'b0, 400, 1'b0);
        #2;
        rst = 1'b1;
        bus.op_valid = 0; bus.op_last = 0; bus.clear = 0;
        #1;
        chk("rst async busy", bus.busy, 0);
        chk("rst async err_range", bus.err_range, 0);
        chk("rst async err_len", bus.err_len, 0);
        chk("rst async out_sum", bus.out_sum, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        g_tmp = tbl[3];
        g_tmp.exp_err_len = 1'b0;
        run_grp(g_tmp, "after rst");

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            cycle(($urandom % 4) != 0, ($urandom % 3) == 0, int'($urandom % Q), ($urandom % 40) == 0);
        end
        repeat (MULT_LAT + 1) cycle(1'b0, 1'b0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
